mcpu_ctrl: RTL and testbench
============================

Name: mcpu_ctrl

Overview:
- Multi-cycle successor to the single-cycle SCPU controller.
- An FSM sequences fetch, decode, execute, memory and write-back for RV32I-subset instructions.
- Memory access stalls on MIO_ready, with an optional timeout. Illegal opcodes trap.
- Sits between the instruction register (IR) fields and the multi-cycle datapath. Also provides retired-instruction and cycle counters for the debug display.

Parameters:
- ALU_W, 4, width of ALU_Control. Codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
- WAIT_MAX, 16, maximum consecutive cycles waiting for MIO_ready before a trap. 0 disables the timeout.
- CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- OPcode  in  5  IR[6:2].
- Fun3  in  3  IR[14:12].
- Fun7  in  1  IR[30].
- zero  in  1  ALU zero flag.
- MIO_ready  in  1  memory/IO ready.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU register.
- MemRW  out  1  1 = write.
- CPU_MIO  out  1  memory request.
- RegWrite  out  1  register-file write enable.
- ImmSel  out  3  immediate format: I 0, S 1, B 2, J 3, U 4.
- ALUSrcA  out  2  ALU A source: 0 = rs1, 1 = OldPC, 2 = zero.
- ALUSrcB  out  2  ALU B source: 0 = rs2, 1 = imm, 2 = constant 4.
- ALU_Control  out  ALU_W  ALU operation.
- MemtoReg  out  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC+4.
- PCSource  out  1  PC source: 0 = ALU out, 1 = ALU register.
- state  out  3  current FSM state, for debug.
- illegal  out  1  sticky flag, illegal opcode.
- mem_err  out  1  sticky flag, memory timeout.
- cycle_cnt  out  CNT_W  free-running cycle count.
- instret_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- **Reset.** Asynchronous, active-high. On reset: state = FETCH, all enables 0, mux selects 0, ALU_Control = ADD, flags 0, counters 0. A reset during a memory wait aborts the access immediately.
- **States:** FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.
- **FETCH.**
  - Drives CPU_MIO=1, IorD=0, MemRW=0, ALUSrcA=2, ALUSrcB=2, ALU_Control=ADD.
  - If MIO_ready=1: IRWrite=1, PCWrite=1, PCSource=0, next state DECODE.
  - Otherwise: hold in FETCH, all write enables 0.
- **DECODE.**
  - ALUSrcA=1, ALUSrcB=1, ImmSel=B (precomputes the branch target).
  - Next state is EXEC for legal opcodes: 01100 R, 00100 I-ALU, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL, 11001 JALR, 01101 LUI, 00101 AUIPC.
  - Any other opcode: next state TRAP, illegal set to 1.
- **EXEC, by class:**
  - R: ALU_Control from Fun3 and Fun7. Fun7 selects SUB over ADD and SRA over SRL. Next WB.
  - I-ALU: same decode, but Fun7 is honoured only for shifts. Next WB.
  - LOAD/STORE: ADD with imm. ImmSel is I for LOAD, S for STORE. Next MEM.
  - BRANCH: SUB on rs1, rs2. Fun3=000 (beq) takes the branch if zero=1; Fun3=001 (bne) takes it if zero=0. Taken: PCWrite=1, PCSource=1. Next FETCH (instruction retires).
  - JAL: ImmSel=J, ALUSrcA=1, ALUSrcB=1. JALR: ImmSel=I, ALUSrcA=0, ALUSrcB=1. Both: PCWrite=1, PCSource=0, next WB with MemtoReg=2. The datapath holds PC+4 from FETCH.
  - LUI: ALUSrcA=2, ImmSel=U. AUIPC: ALUSrcA=1, ImmSel=U. Both next WB.
- **MEM.**
  - CPU_MIO=1, IorD=1, MemRW=1 for STORE and 0 for LOAD.
  - Stalls while MIO_ready=0.
  - On ready: LOAD goes to WB; STORE goes to FETCH (instruction retires).
- **WB.**
  - RegWrite=1 for exactly one cycle. MemtoReg=1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - Next FETCH (instruction retires).
- **Timeout.**
  - A wait counter clears on entry to FETCH or MEM and increments each cycle with MIO_ready=0.
  - If WAIT_MAX≠0 and the counter reaches WAIT_MAX: next state TRAP, mem_err set to 1.
  - MIO_ready arriving in the same cycle as the limit takes priority; no trap.
- **TRAP.** All enables 0, CPU_MIO=0. The FSM stays in TRAP until rst. cycle_cnt keeps counting.
- **Counters.**
  - cycle_cnt increments every cycle.
  - instret_cnt increments on each transition into FETCH from EXEC, MEM or WB.
  - Both wrap modulo 2^CNT_W.
- **Output style.** All outputs are combinational from state, the IR fields, zero and MIO_ready. Write enables are never asserted while a stall is pending.
- **Cycle counts with no wait states:** branch 3, R/I/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5.

Decomposition:
- Shared package `mcpu_pkg`: state encodings, opcode constants, ALU codes, ImmSel/ALUSrc/MemtoReg encodings.
- One sub-module, `mcpu_alu_dec`: combinational mapping from Fun3, Fun7 and instruction class to ALU_Control.

Test Plan:
- add x3,x1,x2 (0x002081B3) with MIO_ready=1 → states 0,1,2,4,0; RegWrite high only in cycle 4; ALU_Control=0; instret_cnt goes 0→1.
- lw (0x0000A183) with MIO_ready low for 3 cycles in MEM → MEM held 3 cycles with MemRW=0, CPU_MIO=1; WB follows; total 8 cycles.
- beq with zero=1, then bne with zero=1 → beq: PCWrite=1, PCSource=1 in EXEC; bne: PCWrite=0; each takes 3 cycles and retires.
- Opcode 11111 → state 7 after DECODE; illegal=1; no further enables; instret_cnt unchanged.
- WAIT_MAX=4, MIO_ready held 0 in FETCH → TRAP after 4 wait cycles, mem_err=1; a repeat with ready on the 4th cycle → no trap.
- rst asserted mid-MEM of a store → state=0, MemRW=0, counters 0 with no clock edge required.

Source files
------------

// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared encodings for the multi-cycle controller.
// States, opcodes, instruction classes, ALU codes and mux selects.
package mcpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [4:0] OP_R     = 5'b01100;
   localparam logic [4:0] OP_I     = 5'b00100;
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_BR    = 5'b11000;
   localparam logic [4:0] OP_JAL   = 5'b11011;
   localparam logic [4:0] OP_JALR  = 5'b11001;
   localparam logic [4:0] OP_LUI   = 5'b01101;
   localparam logic [4:0] OP_AUIPC = 5'b00101;

   typedef enum logic [3:0] {
      C_R, C_I, C_LOAD, C_STORE, C_BR,
      C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
   } cls_t;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] SRCA_RS1  = 2'd0;
   localparam logic [1:0] SRCA_PC   = 2'd1;
   localparam logic [1:0] SRCA_ZERO = 2'd2;
   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   function automatic cls_t op_class(input logic [4:0] op);
      case (op)
         OP_R:     return C_R;
         OP_I:     return C_I;
         OP_LOAD:  return C_LOAD;
         OP_STORE: return C_STORE;
         OP_BR:    return C_BR;
         OP_JAL:   return C_JAL;
         OP_JALR:  return C_JALR;
         OP_LUI:   return C_LUI;
         OP_AUIPC: return C_AUIPC;
         default:  return C_BAD;
      endcase
   endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// mcpu_alu_dec: maps instruction class, Fun3 and Fun7 to an ALU code.
// Ports: cls, fun3, fun7 in; alu_ctrl (ALU_W bits) out.
module mcpu_alu_dec
   import mcpu_pkg::*;
#(
   parameter int ALU_W = 4
) (
   input  cls_t             cls,
   input  logic [2:0]       fun3,
   input  logic             fun7,
   output logic [ALU_W-1:0] alu_ctrl
);

   logic [3:0] op;

   always_comb begin
      op = ALU_ADD;
      case (cls)
         C_R, C_I: begin
            unique case (fun3)
               // Fun7 picks SUB only for register-register ops;
               // addi with IR[30] set is still an add.
               3'b000: op = (cls == C_R && fun7) ? ALU_SUB : ALU_ADD;
               3'b001: op = ALU_SLL;
               3'b010: op = ALU_SLT;
               3'b011: op = ALU_SLTU;
               3'b100: op = ALU_XOR;
               3'b101: op = fun7 ? ALU_SRA : ALU_SRL;
               3'b110: op = ALU_OR;
               3'b111: op = ALU_AND;
            endcase
         end
         C_BR:    op = ALU_SUB;
         default: op = ALU_ADD;
      endcase
      alu_ctrl = ALU_W'(op);
   end

endmodule

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle RV32I-subset controller FSM with memory
// timeout trap, illegal-opcode trap and cycle/retire counters.
// Ports: IR fields (OPcode, Fun3, Fun7), zero, MIO_ready in;
// datapath enables/selects, state, sticky flags, counters out.
module mcpu_ctrl
   import mcpu_pkg::*;
#(
   parameter int ALU_W    = 4,
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       OPcode,
   input  logic [2:0]       Fun3,
   input  logic             Fun7,
   input  logic             zero,
   input  logic             MIO_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             IorD,
   output logic             MemRW,
   output logic             CPU_MIO,
   output logic             RegWrite,
   output logic [2:0]       ImmSel,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [ALU_W-1:0] ALU_Control,
   output logic [1:0]       MemtoReg,
   output logic             PCSource,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             mem_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [WW-1:0] WLIM =
      WW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
   localparam bit TMO_EN = (WAIT_MAX != 0);

   state_t           st_q, st_d;
   cls_t             cls;
   logic [WW-1:0]    wait_q;
   logic [ALU_W-1:0] alu_exec;
   logic             in_wait, timeout, taken, retire;
   logic             set_ill, set_merr;

   assign cls     = op_class(OPcode);
   assign state   = st_q;
   assign in_wait = (st_q == S_FETCH) || (st_q == S_MEM);
   // wait_q counts earlier stalled cycles, so the limit is hit on
   // the WAIT_MAX-th consecutive not-ready cycle; ready wins.
   assign timeout = TMO_EN && in_wait && !MIO_ready && (wait_q == WLIM);
   assign taken   = ((Fun3 == 3'b000) && zero) ||
                    ((Fun3 == 3'b001) && !zero);
   assign retire  = (st_d == S_FETCH) &&
                    ((st_q == S_EXEC) || (st_q == S_MEM) || (st_q == S_WB));

   mcpu_alu_dec #(.ALU_W(ALU_W)) u_alu_dec (
      .cls      (cls),
      .fun3     (Fun3),
      .fun7     (Fun7),
      .alu_ctrl (alu_exec)
   );

   always_comb begin
      st_d        = st_q;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      IorD        = 1'b0;
      MemRW       = 1'b0;
      CPU_MIO     = 1'b0;
      RegWrite    = 1'b0;
      ImmSel      = IMM_I;
      ALUSrcA     = SRCA_RS1;
      ALUSrcB     = SRCB_RS2;
      ALU_Control = ALU_W'(ALU_ADD);
      MemtoReg    = WB_ALU;
      PCSource    = 1'b0;
      set_ill     = 1'b0;
      set_merr    = 1'b0;
      // Reset forces quiet outputs even though FETCH is the reset state.
      if (!rst) begin
         case (st_q)
            S_FETCH: begin
               CPU_MIO = 1'b1;
               ALUSrcA = SRCA_ZERO;
               ALUSrcB = SRCB_FOUR;
               if (MIO_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  st_d    = S_DECODE;
               end else if (timeout) begin
                  set_merr = 1'b1;
                  st_d     = S_TRAP;
               end
            end
            S_DECODE: begin
               ALUSrcA = SRCA_PC;
               ALUSrcB = SRCB_IMM;
               ImmSel  = IMM_B;
               if (cls == C_BAD) begin
                  set_ill = 1'b1;
                  st_d    = S_TRAP;
               end else begin
                  st_d = S_EXEC;
               end
            end
            S_EXEC: begin
               ALU_Control = alu_exec;
               case (cls)
                  C_R: st_d = S_WB;
                  C_I: begin
                     ALUSrcB = SRCB_IMM;
                     st_d    = S_WB;
                  end
                  C_LOAD: begin
                     ALUSrcB = SRCB_IMM;
                     st_d    = S_MEM;
                  end
                  C_STORE: begin
                     ALUSrcB = SRCB_IMM;
                     ImmSel  = IMM_S;
                     st_d    = S_MEM;
                  end
                  C_BR: begin
                     ImmSel   = IMM_B;
                     PCWrite  = taken;
                     PCSource = taken;
                     st_d     = S_FETCH;
                  end
                  C_JAL: begin
                     ImmSel  = IMM_J;
                     ALUSrcA = SRCA_PC;
                     ALUSrcB = SRCB_IMM;
                     PCWrite = 1'b1;
                     st_d    = S_WB;
                  end
                  C_JALR: begin
                     ALUSrcB = SRCB_IMM;
                     PCWrite = 1'b1;
                     st_d    = S_WB;
                  end
                  C_LUI: begin
                     ImmSel  = IMM_U;
                     ALUSrcA = SRCA_ZERO;
                     ALUSrcB = SRCB_IMM;
                     st_d    = S_WB;
                  end
                  C_AUIPC: begin
                     ImmSel  = IMM_U;
                     ALUSrcA = SRCA_PC;
                     ALUSrcB = SRCB_IMM;
                     st_d    = S_WB;
                  end
                  default: begin
                     set_ill = 1'b1;
                     st_d    = S_TRAP;
                  end
               endcase
            end
            S_MEM: begin
               CPU_MIO = 1'b1;
               IorD    = 1'b1;
               MemRW   = (cls == C_STORE);
               if (MIO_ready) begin
                  st_d = (cls == C_STORE) ? S_FETCH : S_WB;
               end else if (timeout) begin
                  set_merr = 1'b1;
                  st_d     = S_TRAP;
               end
            end
            S_WB: begin
               RegWrite = 1'b1;
               unique case (1'b1)
                  cls == C_LOAD:                   MemtoReg = WB_MEM;
                  cls == C_JAL || cls == C_JALR:   MemtoReg = WB_PC4;
                  default:                         MemtoReg = WB_ALU;
               endcase
               st_d = S_FETCH;
            end
            S_TRAP:  st_d = S_TRAP;
            default: st_d = S_TRAP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= S_FETCH;
         wait_q      <= '0;
         illegal     <= 1'b0;
         mem_err     <= 1'b0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         st_q      <= st_d;
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (TMO_EN && in_wait && !MIO_ready)
            wait_q <= wait_q + WW'(1);
         else
            wait_q <= '0;
         if (set_ill)
            illegal <= 1'b1;
         if (set_merr)
            mem_err <= 1'b1;
         if (retire)
            instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: table vectors, corner sequences and random
// instruction streams against a phase-list reference model.
module tb_mcpu_ctrl;

   localparam int WMAX = 4;

   localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
   localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUI = 8;
   localparam int K_BAD = 9;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  OPcode = '0;
   logic [2:0]  Fun3 = '0;
   logic        Fun7 = 1'b0;
   logic        zero = 1'b0;
   logic        MIO_ready = 1'b0;
   logic        PCWrite, IRWrite, IorD, MemRW, CPU_MIO, RegWrite;
   logic [2:0]  ImmSel;
   logic [1:0]  ALUSrcA, ALUSrcB, MemtoReg;
   logic [3:0]  ALU_Control;
   logic        PCSource;
   logic [2:0]  state;
   logic        illegal, mem_err;
   logic [31:0] cycle_cnt, instret_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cyc = 0;
   int exp_ret = 0;

   always #5 clk = ~clk;

   mcpu_ctrl #(.ALU_W(4), .WAIT_MAX(WMAX), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .OPcode(OPcode), .Fun3(Fun3),
      .Fun7(Fun7), .zero(zero), .MIO_ready(MIO_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
      .MemRW(MemRW), .CPU_MIO(CPU_MIO), .RegWrite(RegWrite),
      .ImmSel(ImmSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALU_Control(ALU_Control), .MemtoReg(MemtoReg),
      .PCSource(PCSource), .state(state), .illegal(illegal),
      .mem_err(mem_err), .cycle_cnt(cycle_cnt),
      .instret_cnt(instret_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int kind(input logic [4:0] op);
      case (op)
         5'b01100: return K_R;
         5'b00100: return K_I;
         5'b00000: return K_LD;
         5'b01000: return K_ST;
         5'b11000: return K_BR;
         5'b11011: return K_JAL;
         5'b11001: return K_JALR;
         5'b01101: return K_LUI;
         5'b00101: return K_AUI;
         default:  return K_BAD;
      endcase
   endfunction

   // ALU op by Fun3 for arithmetic classes, with the two Fun7 variants.
   function automatic int exp_alu(input int k, input int f3, input bit f7);
      int t[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
      int r;
      if (k == K_BR) return 1;
      if (k != K_R && k != K_I) return 0;
      r = t[f3];
      if (f3 == 0 && k == K_R && f7) r = 1;
      if (f3 == 5 && f7) r = 9;
      return r;
   endfunction

   function automatic bit br_taken(input int f3, input bit z);
      return (f3 == 0 && z) || (f3 == 1 && !z);
   endfunction

   // {PCWrite, IRWrite, IorD, MemRW, CPU_MIO, RegWrite}
   function automatic logic [5:0] exp_ctrl(input int st, input int k,
      input bit rdy, input bit z, input int f3);
      bit pcw;
      case (st)
         0: return {rdy, rdy, 1'b0, 1'b0, 1'b1, 1'b0};
         2: begin
            pcw = (k == K_JAL) || (k == K_JALR) ||
                  (k == K_BR && br_taken(f3, z));
            return {pcw, 5'b0};
         end
         3: return {2'b00, 1'b1, (k == K_ST), 1'b1, 1'b0};
         4: return 6'b000001;
         default: return 6'b0;
      endcase
   endfunction

   // {ALUSrcA, ALUSrcB}; imm returned separately, -1 when unspecified.
   function automatic logic [3:0] exp_src(input int st, input int k,
                                          output int imm);
      imm = -1;
      if (st == 0) return {2'd2, 2'd2};
      if (st == 1) begin imm = 2; return {2'd1, 2'd1}; end
      case (k)
         K_R, K_BR: return 4'b0000;
         K_I, K_LD, K_JALR: begin imm = 0; return {2'd0, 2'd1}; end
         K_ST:  begin imm = 1; return {2'd0, 2'd1}; end
         K_JAL: begin imm = 3; return {2'd1, 2'd1}; end
         K_LUI: begin imm = 4; return {2'd2, 2'd1}; end
         default: begin imm = 4; return {2'd1, 2'd1}; end
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_state", state, 0);
      chk("rst_ctrl", {PCWrite, IRWrite, IorD, MemRW, CPU_MIO, RegWrite}, 0);
      chk("rst_sel", {ImmSel, ALUSrcA, ALUSrcB, MemtoReg, PCSource,
                      ALU_Control}, 0);
      chk("rst_flags", {illegal, mem_err}, 0);
      chk("rst_cnt", {cycle_cnt, instret_cnt}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cyc = 0;
      exp_ret = 0;
   endtask

   // Runs one instruction from FETCH; fw/mw are not-ready cycles
   // before ready in FETCH/MEM. Expected phases follow the class.
   task automatic run_instr(input logic [4:0] op, input logic [2:0] f3,
      input bit f7, input bit z, input int fw, input int mw,
      output int ncyc, output int alu_seen, output bit trapped);
      int k = kind(op);
      int q[$];
      bit rq[$];
      int why = 0;
      int st, imm;
      bit pcw_exp;
      logic [3:0] src;
      trapped = 0;
      alu_seen = -1;
      for (int i = 0; i < fw && i < WMAX; i++) begin
         q.push_back(0); rq.push_back(0);
      end
      if (fw >= WMAX) begin
         why = 2;
      end else begin
         q.push_back(0); rq.push_back(1);
         q.push_back(1); rq.push_back(1'($urandom));
         if (k == K_BAD) begin
            why = 1;
         end else begin
            q.push_back(2); rq.push_back(1'($urandom));
            if (k == K_LD || k == K_ST) begin
               for (int i = 0; i < mw && i < WMAX; i++) begin
                  q.push_back(3); rq.push_back(0);
               end
               if (mw >= WMAX) why = 2;
               else begin
                  q.push_back(3); rq.push_back(1);
                  if (k == K_LD) begin
                     q.push_back(4); rq.push_back(1'($urandom));
                  end
               end
            end else if (k != K_BR) begin
               q.push_back(4); rq.push_back(1'($urandom));
            end
         end
      end
      if (why != 0) begin
         trapped = 1;
         repeat (2) begin
            q.push_back(7); rq.push_back(1'($urandom));
         end
      end
      OPcode = op; Fun3 = f3; Fun7 = f7; zero = z;
      foreach (q[i]) begin
         st = q[i];
         MIO_ready = rq[i];
         #4;
         chk("state", state, st);
         chk("ctrl", {PCWrite, IRWrite, IorD, MemRW, CPU_MIO, RegWrite},
             exp_ctrl(st, k, rq[i], z, f3));
         chk("cycle_cnt", cycle_cnt, exp_cyc);
         chk("instret", instret_cnt, exp_ret);
         chk("flags", {illegal, mem_err},
             (st == 7) ? ((why == 1) ? 2 : 1) : 0);
         if (st <= 2) begin
            src = exp_src(st, k, imm);
            chk("alusrc", {ALUSrcA, ALUSrcB}, src);
            if (imm >= 0) chk("immsel", ImmSel, imm);
         end
         if (st == 2) begin
            chk("alu", ALU_Control, exp_alu(k, f3, f7));
            alu_seen = ALU_Control;
         end
         if (st == 4)
            chk("memtoreg", MemtoReg, (k == K_LD) ? 1 :
                (k == K_JAL || k == K_JALR) ? 2 : 0);
         pcw_exp = exp_ctrl(st, k, rq[i], z, f3) >> 5;
         if (pcw_exp)
            chk("pcsource", PCSource, (st == 2 && k == K_BR));
         @(posedge clk);
         #1;
         exp_cyc++;
      end
      if (!trapped) exp_ret++;
      ncyc = q.size();
   endtask

   typedef struct {
      logic [4:0] op;
      logic [2:0] f3;
      bit         f7;
      bit         z;
      int         alu;
      int         ncyc;
   } vec_t;

   vec_t tv[$];
   logic [4:0] legal_ops[9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000,
      5'b11000, 5'b11011, 5'b11001, 5'b01101, 5'b00101};

   initial begin
      int n, a, fw, mw;
      bit tr;
      logic [4:0] op;
      tv.push_back('{5'b01100, 3'd0, 1'b0, 1'b0, 0, 4});
      tv.push_back('{5'b01100, 3'd0, 1'b1, 1'b0, 1, 4});
      tv.push_back('{5'b01100, 3'd1, 1'b0, 1'b0, 7, 4});
      tv.push_back('{5'b01100, 3'd2, 1'b0, 1'b0, 5, 4});
      tv.push_back('{5'b01100, 3'd3, 1'b0, 1'b0, 6, 4});
      tv.push_back('{5'b01100, 3'd4, 1'b0, 1'b0, 4, 4});
      tv.push_back('{5'b01100, 3'd5, 1'b0, 1'b0, 8, 4});
      tv.push_back('{5'b01100, 3'd5, 1'b1, 1'b0, 9, 4});
      tv.push_back('{5'b01100, 3'd6, 1'b0, 1'b0, 3, 4});
      tv.push_back('{5'b01100, 3'd7, 1'b0, 1'b0, 2, 4});
      tv.push_back('{5'b00100, 3'd0, 1'b1, 1'b0, 0, 4});
      tv.push_back('{5'b00100, 3'd5, 1'b1, 1'b0, 9, 4});
      tv.push_back('{5'b00100, 3'd5, 1'b0, 1'b0, 8, 4});
      tv.push_back('{5'b00000, 3'd2, 1'b0, 1'b0, 0, 5});
      tv.push_back('{5'b01000, 3'd2, 1'b0, 1'b0, 0, 4});
      tv.push_back('{5'b11000, 3'd0, 1'b0, 1'b1, 1, 3});
      tv.push_back('{5'b11000, 3'd1, 1'b0, 1'b1, 1, 3});
      tv.push_back('{5'b11011, 3'd0, 1'b0, 1'b0, 0, 4});
      tv.push_back('{5'b11001, 3'd0, 1'b0, 1'b0, 0, 4});
      tv.push_back('{5'b01101, 3'd0, 1'b0, 1'b0, 0, 4});
      tv.push_back('{5'b00101, 3'd0, 1'b0, 1'b0, 0, 4});

      #2;
      do_reset();

      foreach (tv[i]) begin
         run_instr(tv[i].op, tv[i].f3, tv[i].f7, tv[i].z, 0, 0, n, a, tr);
         chk("tv_cycles", n, tv[i].ncyc);
         chk("tv_alu", a, tv[i].alu);
      end
      chk("tv_instret", instret_cnt, tv.size());

      // lw with three stalled MEM cycles
      run_instr(5'b00000, 3'd2, 1'b0, 1'b0, 0, 3, n, a, tr);
      chk("lw_wait_cycles", n, 8);

      // ready on the 4th FETCH cycle: no trap
      run_instr(5'b01100, 3'd0, 1'b0, 1'b0, 3, 0, n, a, tr);
      chk("fetch_late_ready", {tr, 8'(n)}, {1'b0, 8'd7});

      // FETCH timeout
      run_instr(5'b01100, 3'd0, 1'b0, 1'b0, 4, 0, n, a, tr);
      chk("fetch_timeout", tr, 1);
      do_reset();

      // MEM timeout on a store
      run_instr(5'b01000, 3'd2, 1'b0, 1'b0, 0, 4, n, a, tr);
      chk("mem_timeout", tr, 1);
      do_reset();

      // illegal opcode after one retired instruction
      run_instr(5'b01100, 3'd0, 1'b0, 1'b0, 0, 0, n, a, tr);
      run_instr(5'b11111, 3'd0, 1'b0, 1'b0, 0, 0, n, a, tr);
      chk("illegal_trap", tr, 1);
      chk("illegal_instret", instret_cnt, 1);
      do_reset();

      // reset in the middle of a stalled store
      run_instr(5'b01100, 3'd0, 1'b0, 1'b0, 0, 0, n, a, tr);
      OPcode = 5'b01000;
      MIO_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         exp_cyc++;
         MIO_ready = 1'b0;
      end
      #1;
      chk("mid_mem_state", {state, MemRW, CPU_MIO}, {3'd3, 1'b1, 1'b1});
      chk("mid_mem_cnt", cycle_cnt, exp_cyc);
      rst = 1'b1;
      #1;
      chk("async_rst", {state, MemRW, CPU_MIO}, 0);
      chk("async_rst_cnt", {cycle_cnt, instret_cnt}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cyc = 0;
      exp_ret = 0;

      // random instruction stream
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 19) == 0) op = 5'b11111;
         else op = legal_ops[$urandom_range(0, 8)];
         fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3)
                                         : $urandom_range(4, 5);
         mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3)
                                         : $urandom_range(4, 5);
         run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                   fw, mw, n, a, tr);
         if (tr) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
